// File: rtl/chip8_timers.sv
// chip8_timers: clock-divided instruction strobe and 60 Hz tick for the CHIP-8 core,
// plus the delay (DT) and sound (ST) timers and the buzzer tone generator.
// Ports:
//   clk_in            system clock (single domain)
//   rst_n_in          asynchronous active-low reset
//   active_in         1 = run, 0 = pause (dividers, timers and tone frozen)
//   dt_we_in          load data_in into DT this cycle
//   st_we_in          load data_in into ST this cycle
//   data_in[7:0]      write value for DT/ST
//   chip8_clk_out     one-cycle instruction strobe, period INSTR_DIV
//   timer_tick_out    one-cycle timer strobe, period TIMER_DIV
//   delay_out[7:0]    current DT value
//   sound_active_out  ST != 0 (decoded directly from the ST register)
//   tone_out          buzzer square wave, half period TONE_HALF cycles
module chip8_timers #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned INSTR_HZ = 700,
  parameter int unsigned TIMER_HZ = 60,
  parameter int unsigned TONE_HZ  = 440
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       active_in,
  input  logic       dt_we_in,
  input  logic       st_we_in,
  input  logic [7:0] data_in,
  output logic       chip8_clk_out,
  output logic       timer_tick_out,
  output logic [7:0] delay_out,
  output logic       sound_active_out,
  output logic       tone_out
);

  localparam int unsigned INSTR_DIV = CLK_HZ / INSTR_HZ;
  localparam int unsigned TIMER_DIV = CLK_HZ / TIMER_HZ;
  localparam int unsigned TONE_HALF = CLK_HZ / (2 * TONE_HZ);

  // Counter widths; a half period of 1 still needs a 1-bit counter.
  localparam int unsigned INSTR_W = (INSTR_DIV > 1) ? $clog2(INSTR_DIV) : 1;
  localparam int unsigned TIMER_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam int unsigned TONE_W  = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  localparam logic [INSTR_W-1:0] INSTR_LAST = INSTR_W'(INSTR_DIV - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMER_DIV - 1);
  localparam logic [TONE_W-1:0]  TONE_LAST  = TONE_W'(TONE_HALF - 1);

  logic [INSTR_W-1:0] instr_cnt;
  logic [TIMER_W-1:0] timer_cnt;
  logic [TONE_W-1:0]  tone_cnt;
  logic [7:0]         dt_q;
  logic [7:0]         st_q;
  logic [7:0]         dt_nxt;
  logic [7:0]         st_nxt;
  logic               instr_tick;
  logic               timer_tick;

  // Terminal count while running; the strobes are these conditions delayed one cycle.
  assign instr_tick = active_in && (instr_cnt == INSTR_LAST);
  assign timer_tick = active_in && (timer_cnt == TIMER_LAST);

  // Instruction divider and strobe register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      instr_cnt     <= '0;
      chip8_clk_out <= 1'b0;
    end else begin
      chip8_clk_out <= instr_tick;
      if (active_in) begin
        instr_cnt <= (instr_cnt == INSTR_LAST) ? '0 : instr_cnt + INSTR_W'(1);
      end
    end
  end

  // Timer divider and tick register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      timer_cnt      <= '0;
      timer_tick_out <= 1'b0;
    end else begin
      timer_tick_out <= timer_tick;
      if (active_in) begin
        timer_cnt <= (timer_cnt == TIMER_LAST) ? '0 : timer_cnt + TIMER_W'(1);
      end
    end
  end

  // DT/ST next value: a write beats a coincident tick; decrement saturates at zero.
  always_comb begin
    dt_nxt = dt_q;
    st_nxt = st_q;
    if (dt_we_in) begin
      dt_nxt = data_in;
    end else if (timer_tick && (dt_q != 8'd0)) begin
      dt_nxt = dt_q - 8'd1;
    end
    if (st_we_in) begin
      st_nxt = data_in;
    end else if (timer_tick && (st_q != 8'd0)) begin
      st_nxt = st_q - 8'd1;
    end
  end

  // Timer registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dt_q <= 8'd0;
      st_q <= 8'd0;
    end else begin
      dt_q <= dt_nxt;
      st_q <= st_nxt;
    end
  end

  assign delay_out        = dt_q;
  assign sound_active_out = (st_q != 8'd0);

  // Tone generator: runs while ST is non-zero and active, holds when paused,
  // and is cleared (phase and level) whenever ST is zero.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tone_cnt <= '0;
      tone_out <= 1'b0;
    end else if (!sound_active_out) begin
      tone_cnt <= '0;
      tone_out <= 1'b0;
    end else if (active_in) begin
      if (tone_cnt == TONE_LAST) begin
        tone_cnt <= '0;
        tone_out <= ~tone_out;
      end else begin
        tone_cnt <= tone_cnt + TONE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_chip8_timers.sv
// tb_chip8_timers: directed scenarios plus randomized traffic for chip8_timers,
// compared every cycle against an arithmetic model of the timer behaviour.
module tb_chip8_timers;

  localparam int unsigned DIV_I = 10;
  localparam int unsigned DIV_T = 20;
  localparam int unsigned HALF  = 5;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       active = 1'b0;
  logic       dt_we  = 1'b0;
  logic       st_we  = 1'b0;
  logic [7:0] data   = 8'd0;
  logic       chip8_clk;
  logic       timer_tick;
  logic [7:0] delay;
  logic       sound_active;
  logic       tone;

  int checks = 0;
  int errors = 0;
  int k      = 0;

  chip8_timers #(
    .CLK_HZ  (1000),
    .INSTR_HZ(100),
    .TIMER_HZ(50),
    .TONE_HZ (100)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .active_in       (active),
    .dt_we_in        (dt_we),
    .st_we_in        (st_we),
    .data_in         (data),
    .chip8_clk_out   (chip8_clk),
    .timer_tick_out  (timer_tick),
    .delay_out       (delay),
    .sound_active_out(sound_active),
    .tone_out        (tone)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: strobes fall on every DIV-th active cycle since reset; tone level is the
  // parity of (sounding active cycles / HALF), restarted whenever ST reads zero.
  int m_act;
  int m_dt;
  int m_st;
  int m_n;
  bit m_ci;
  bit m_tt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_dt = 0; m_st = 0; m_n = 0; m_ci = 0; m_tt = 0;
    end else begin
      int st_old;
      st_old = m_st;
      if (active) m_act++;
      m_ci = active && (m_act % DIV_I == 0);
      m_tt = active && (m_act % DIV_T == 0);
      if (dt_we) m_dt = int'(data);
      else if (m_tt && m_dt > 0) m_dt--;
      if (st_we) m_st = int'(data);
      else if (m_tt && m_st > 0) m_st--;
      if (st_old == 0) m_n = 0;
      else if (active) m_n++;
    end
  end

  always @(negedge clk) begin
    check("chip8_clk", 32'(chip8_clk), 32'(m_ci));
    check("timer_tick", 32'(timer_tick), 32'(m_tt));
    check("delay", 32'(delay), 32'(m_dt));
    check("sound_active", 32'(sound_active), 32'(m_st != 0));
    check("tone", 32'(tone), 32'((m_n / HALF) % 2));
  end

  task automatic wait_to(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic async_reset_pulse();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_chip8_clk", 32'(chip8_clk), 32'd0);
    check("rst_timer_tick", 32'(timer_tick), 32'd0);
    check("rst_delay", 32'(delay), 32'd0);
    check("rst_sound", 32'(sound_active), 32'd0);
    check("rst_tone", 32'(tone), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_delay", 32'(delay), 32'd0);
    check("reset_instr", 32'(chip8_clk), 32'd0);
    rst_n = 1'b1;
    active = 1'b1;
    k = 0;

    // Strobe timing after release.
    wait_to(9);   check("instr_pre", 32'(chip8_clk), 32'd0);
    wait_to(10);  check("instr_first", 32'(chip8_clk), 32'd1);
    wait_to(11);  check("instr_width", 32'(chip8_clk), 32'd0);
    wait_to(19);  check("tick_pre", 32'(timer_tick), 32'd0);
    wait_to(20);  check("tick_first", 32'(timer_tick), 32'd1);

    // DT=3 counts down to 0 and stays there.
    dt_we = 1'b1; data = 8'd3;
    wait_to(21);  dt_we = 1'b0; check("dt_write", 32'(delay), 32'd3);
    wait_to(40);  check("dt_2", 32'(delay), 32'd2);
    wait_to(60);  check("dt_1", 32'(delay), 32'd1);
    wait_to(80);  check("dt_0", 32'(delay), 32'd0);
    wait_to(100); check("dt_sat", 32'(delay), 32'd0);

    // Write coincident with a tick wins.
    wait_to(119); dt_we = 1'b1; data = 8'd5;
    wait_to(120); dt_we = 1'b0;
    check("dt_wr_tick", 32'(delay), 32'd5);
    check("tick_at_wr", 32'(timer_tick), 32'd1);
    wait_to(140); check("dt_after_wr_tick", 32'(delay), 32'd4);

    // ST=2: tone toggles every 5 clk, silenced after two ticks.
    st_we = 1'b1; data = 8'd2;
    wait_to(141); st_we = 1'b0; check("st_sound_on", 32'(sound_active), 32'd1);
    wait_to(145); check("tone_lo", 32'(tone), 32'd0);
    wait_to(146); check("tone_hi", 32'(tone), 32'd1);
    wait_to(151); check("tone_lo2", 32'(tone), 32'd0);
    wait_to(160); check("st_one", 32'(sound_active), 32'd1);
    wait_to(180); check("st_off", 32'(sound_active), 32'd0);
    wait_to(181); check("tone_off", 32'(tone), 32'd0);

    // Pause 37 clk with DT=4.
    wait_to(185); dt_we = 1'b1; data = 8'd4; active = 1'b0;
    wait_to(186); dt_we = 1'b0;
    wait_to(200); check("pause_dt", 32'(delay), 32'd4);
    wait_to(222); active = 1'b1;
    wait_to(226); check("resume_instr_pre", 32'(chip8_clk), 32'd0);
    wait_to(227); check("resume_instr", 32'(chip8_clk), 32'd1);
    wait_to(237); check("resume_tick", 32'(timer_tick), 32'd1);
    check("resume_dt", 32'(delay), 32'd3);

    // Asynchronous reset mid-count with DT=ST=9.
    wait_to(240); dt_we = 1'b1; st_we = 1'b1; data = 8'd9;
    wait_to(241); dt_we = 1'b0; st_we = 1'b0;
    check("both_we", 32'(delay), 32'd9);
    wait_to(245);
    async_reset_pulse();
    wait_to(9);   check("rel_instr_pre", 32'(chip8_clk), 32'd0);
    wait_to(10);  check("rel_instr", 32'(chip8_clk), 32'd1);
    wait_to(20);  check("rel_tick", 32'(timer_tick), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      active = ($urandom_range(0, 9) != 0);
      dt_we  = ($urandom_range(0, 29) == 0);
      st_we  = ($urandom_range(0, 29) == 0);
      data   = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                           : 8'($urandom_range(0, 5));
      if ($urandom_range(0, 699) == 0) async_reset_pulse();
    end
    @(negedge clk);
    dt_we = 1'b0; st_we = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
